// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
// Contents: FSM state encoding, bus owner encoding, word-select helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_LS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int INSN_W = 32;

    // Pick the 32-bit instruction out of a 64-bit memory word.
    function automatic logic [INSN_W-1:0] select_word(input logic [DATA_W-1:0] d,
                                                      input logic hi);
        return hi ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory bus signals of the arbiter
// Modports: slave = arbiter side (serves fetch/ls, drives memory),
//           master = environment side (cores and memory).
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_ready;
    logic [INSN_W-1:0]   if_rdata;

    logic                ls_req;
    logic                ls_wen;
    logic [ADDR_W-1:0]   ls_addr;
    logic [DATA_W-1:0]   ls_wdata;
    logic [MASK_W-1:0]   ls_wmask;
    logic                ls_ready;
    logic [DATA_W-1:0]   ls_rdata;

    logic                mem_valid;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MASK_W-1:0]   mem_wmask;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    logic                bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
        output ls_ready, ls_rdata,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata,
        output bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
        input  ls_ready, ls_rdata,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata,
        input  bus_err
    );

endinterface

// File: rtl/mem_arbiter_bus_timer.sv
// rtl/mem_arbiter_bus_timer.sv - wait-cycle counter that aborts stalled memory beats
// Ports: clk, rst (async, active-high); enable = bus cycle without mem_ready;
//        clear = not on the bus; expired = this is wait cycle number TIMEOUT.
module bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count holds the number of wait cycles already elapsed, so the
    // TIMEOUT-th wait cycle is the one seen with count == TIMEOUT-1.
    assign expired = enable && (count >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and load/store onto one memory port
// Ports: clk, rst (async, active-high); bus = mem_arbiter_if.slave carrying the
//        fetch, load/store and memory handshakes plus the sticky bus_err flag.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);
    import mem_arb_pkg::*;

    arb_state_t state;
    owner_t     last_grant;
    logic       addr_hi;
    logic       in_bus;
    logic       grant_ls;
    logic       timer_en;
    logic       timer_clr;
    logic       timer_exp;

    assign in_bus = (state == BUS_IF) || (state == BUS_LS);

    // On a tie, the requester that did not win last time gets the bus.
    assign grant_ls = bus.ls_req && (!bus.if_req || (last_grant == OWN_IF));

    assign timer_en  = in_bus && !bus.mem_ready;
    assign timer_clr = !in_bus;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_en),
        .clear   (timer_clr),
        .expired (timer_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= OWN_IF;
            addr_hi       <= 1'b0;
            bus.if_ready  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_ready  <= 1'b0;
            bus.ls_rdata  <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_wen   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wmask <= '0;
            bus.bus_err   <= 1'b0;
        end else begin
            // Ready strobes last exactly the one RESP cycle.
            bus.if_ready <= 1'b0;
            bus.ls_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.if_req || bus.ls_req) begin
                        bus.mem_valid <= 1'b1;
                        if (grant_ls) begin
                            state         <= BUS_LS;
                            last_grant    <= OWN_LS;
                            bus.mem_wen   <= bus.ls_wen;
                            bus.mem_addr  <= bus.ls_addr;
                            bus.mem_wdata <= bus.ls_wdata;
                            bus.mem_wmask <= bus.ls_wmask;
                        end else begin
                            state         <= BUS_IF;
                            last_grant    <= OWN_IF;
                            addr_hi       <= bus.if_addr[2];
                            bus.mem_wen   <= 1'b0;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= '0;
                            bus.mem_wmask <= '0;
                        end
                    end
                end

                BUS_IF, BUS_LS: begin
                    // A timed-out beat completes like a normal one, but with zero data.
                    if (bus.mem_ready || timer_exp) begin
                        state         <= RESP;
                        bus.mem_valid <= 1'b0;
                        if (!bus.mem_ready) begin
                            bus.bus_err <= 1'b1;
                        end
                        if (state == BUS_IF) begin
                            bus.if_ready <= 1'b1;
                            bus.if_rdata <= bus.mem_ready ?
                                            select_word(bus.mem_rdata, addr_hi) : '0;
                        end else begin
                            bus.ls_ready <= 1'b1;
                            bus.ls_rdata <= (bus.mem_ready && !bus.mem_wen) ?
                                            bus.mem_rdata : '0;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
